// File: rtl/dsp_pd_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pd_pkg
// Shared definitions for the DSP multiply / pattern-detect arbiter slice.
//   - default parameter values for requester count and datapath widths
//   - pd_match(): masked pattern compare, mask bit = 1 ignores that bit
//   - rr_next(): round-robin successor index with wrap to 0
// ---------------------------------------------------------------------------
package dsp_pd_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_A_W     = 27;
    localparam int DEF_B_W     = 15;
    localparam int DEF_P_W     = DEF_A_W + DEF_B_W;
    localparam int DEF_ID_W    = 2;

    // Width the compare helper works at; callers zero-extend into it.
    // Zero-extending product and pattern alike keeps the unused upper bits
    // equal, so they never cause a false mismatch.
    localparam int PD_MAX_W = 64;

    function automatic logic pd_match(input logic [PD_MAX_W-1:0] prod,
                                      input logic [PD_MAX_W-1:0] pattern,
                                      input logic [PD_MAX_W-1:0] mask);
        return (((prod ^ pattern) & ~mask) == '0);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dsp_pd_pipe.sv
// ---------------------------------------------------------------------------
// dsp_pd_pipe
// Three-stage signed multiply + masked pattern-detect pipeline with a
// requester tag carried alongside the data. All stages shift together when
// adv is high and hold completely when it is low (rigid shift register,
// bubbles are kept).
//   stage 1 : operand register (a, b, pattern, mask, id, valid)
//   stage 2 : full-precision signed product, pattern, mask, id, valid
//   stage 3 : output register (valid, id, product, match flag)
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   adv                     shift enable for every stage
//   in_valid/in_a/in_b      stage-1 load: valid flag and signed operands
//   in_pattern/in_mask      compare pattern and ignore-mask
//   in_id                   requester tag
//   out_valid/out_id        registered response valid and tag
//   out_prod/out_match      registered product and pattern-match flag
// ---------------------------------------------------------------------------
module dsp_pd_pipe
    import dsp_pd_pkg::*;
#(
    parameter int A_W  = DEF_A_W,
    parameter int B_W  = DEF_B_W,
    parameter int P_W  = DEF_P_W,
    parameter int ID_W = DEF_ID_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            adv,
    input  logic            in_valid,
    input  logic [A_W-1:0]  in_a,
    input  logic [B_W-1:0]  in_b,
    input  logic [P_W-1:0]  in_pattern,
    input  logic [P_W-1:0]  in_mask,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [P_W-1:0]  out_prod,
    output logic            out_match
);

    logic                  s1_valid;
    logic signed [A_W-1:0] s1_a;
    logic signed [B_W-1:0] s1_b;
    logic [P_W-1:0]        s1_pattern;
    logic [P_W-1:0]        s1_mask;
    logic [ID_W-1:0]       s1_id;

    logic                  s2_valid;
    logic [P_W-1:0]        s2_prod;
    logic [P_W-1:0]        s2_pattern;
    logic [P_W-1:0]        s2_mask;
    logic [ID_W-1:0]       s2_id;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod_full;
    logic                  s2_match;

    // Both operands are sign-extended to the product width first; since
    // P_W = A_W + B_W the truncated P_W x P_W product is the exact result.
    assign a_ext     = P_W'(s1_a);
    assign b_ext     = P_W'(s1_b);
    assign prod_full = a_ext * b_ext;

    assign s2_match = pd_match(PD_MAX_W'(s2_prod),
                               PD_MAX_W'(s2_pattern),
                               PD_MAX_W'(s2_mask));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_pattern <= '0;
            s1_mask    <= '0;
            s1_id      <= '0;
            s2_valid   <= 1'b0;
            s2_prod    <= '0;
            s2_pattern <= '0;
            s2_mask    <= '0;
            s2_id      <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_prod   <= '0;
            out_match  <= 1'b0;
        end else if (adv) begin
            // Data fields load unconditionally; they are meaningless while
            // the matching valid bit is low.
            s1_valid   <= in_valid;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_pattern <= in_pattern;
            s1_mask    <= in_mask;
            s1_id      <= in_id;

            s2_valid   <= s1_valid;
            s2_prod    <= prod_full;
            s2_pattern <= s1_pattern;
            s2_mask    <= s1_mask;
            s2_id      <= s1_id;

            out_valid  <= s2_valid;
            out_id     <= s2_id;
            out_prod   <= s2_prod;
            out_match  <= s2_match;
        end
    end

endmodule

// File: rtl/dsp_pd_arbiter.sv
// ---------------------------------------------------------------------------
// dsp_pd_arbiter
// Round-robin front end sharing one dsp_pd_pipe between NUM_REQ requesters.
// At most one operand set is accepted per cycle; the winner's ID travels
// with the data and comes back on the single response channel.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   req_valid_i      per-requester request valid
//   req_ready_o      per-requester grant, one-hot or zero
//   a_i, b_i         packed signed operands, requester i in slice i
//   pattern_i        packed compare patterns
//   mask_i           packed masks, bit = 1 ignores that bit in the compare
//   rsp_valid_o      response valid, held until rsp_ready_i
//   rsp_ready_i      response consumer ready
//   rsp_id_o         requester ID of the response
//   rsp_prod_o       signed product a*b, full precision
//   rsp_match_o      1 when ((prod ^ pattern) & ~mask) == 0
// ---------------------------------------------------------------------------
module dsp_pd_arbiter
    import dsp_pd_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*A_W-1:0] a_i,
    input  logic [NUM_REQ*B_W-1:0] b_i,
    input  logic [NUM_REQ*P_W-1:0] pattern_i,
    input  logic [NUM_REQ*P_W-1:0] mask_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [P_W-1:0]         rsp_prod_o,
    output logic                   rsp_match_o
);

    logic            adv;
    logic            accept;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_found;

    logic [A_W-1:0]  a_sel;
    logic [B_W-1:0]  b_sel;
    logic [P_W-1:0]  pattern_sel;
    logic [P_W-1:0]  mask_sel;

    // The whole pipeline moves as one: it may advance whenever the output
    // slot is empty or being consumed this cycle.
    assign adv = !rsp_valid_o || rsp_ready_i;

    // Search from the pointer upward, wrapping; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant is suppressed under reset so nothing looks accepted while the
    // pipeline is being cleared (adv alone would be 1 then).
    always_comb begin
        req_ready_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rst_ni && adv && gnt_found && (gnt_idx == ID_W'(r))) begin
                req_ready_o[r] = 1'b1;
            end
        end
    end

    assign accept = |(req_valid_i & req_ready_o);

    always_comb begin
        a_sel       = '0;
        b_sel       = '0;
        pattern_sel = '0;
        mask_sel    = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_idx == ID_W'(r)) begin
                a_sel       = a_i[r*A_W +: A_W];
                b_sel       = b_i[r*B_W +: B_W];
                pattern_sel = pattern_i[r*P_W +: P_W];
                mask_sel    = mask_i[r*P_W +: P_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ID_W'(rr_next(int'(gnt_idx), NUM_REQ));
        end
    end

    dsp_pd_pipe #(
        .A_W  (A_W),
        .B_W  (B_W),
        .P_W  (P_W),
        .ID_W (ID_W)
    ) u_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .adv        (adv),
        .in_valid   (accept),
        .in_a       (a_sel),
        .in_b       (b_sel),
        .in_pattern (pattern_sel),
        .in_mask    (mask_sel),
        .in_id      (gnt_idx),
        .out_valid  (rsp_valid_o),
        .out_id     (rsp_id_o),
        .out_prod   (rsp_prod_o),
        .out_match  (rsp_match_o)
    );

endmodule

// File: tb/tb_dsp_pd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dsp_pd_arbiter
// Self-checking bench for dsp_pd_arbiter. Accepted requests push their
// expected response onto a scoreboard queue; responses pop and compare.
// A round-robin reference pointer predicts every grant vector.
// ---------------------------------------------------------------------------
module tb_dsp_pd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int A_W     = 27;
    localparam int B_W     = 15;
    localparam int P_W     = 42;
    localparam int ID_W    = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] a_bus;
    logic [NUM_REQ*B_W-1:0] b_bus;
    logic [NUM_REQ*P_W-1:0] pat_bus;
    logic [NUM_REQ*P_W-1:0] mask_bus;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_prod;
    logic                   rsp_match;

    logic signed [A_W-1:0] a_arr    [NUM_REQ];
    logic signed [B_W-1:0] b_arr    [NUM_REQ];
    logic [P_W-1:0]        pat_arr  [NUM_REQ];
    logic [P_W-1:0]        mask_arr [NUM_REQ];
    int                    remaining[NUM_REQ];

    typedef struct {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  prod;
        logic            match;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_ptr = 0;
    int rsp_count = 0;
    int acc_count = 0;
    int last_acc_cyc = 0;
    int last_rsp_cyc = 0;
    int first_rsp_cyc = 0;
    bit mark_first = 1'b0;
    logic [ID_W-1:0] last_id;
    logic [P_W-1:0]  last_prod;
    logic            last_match;

    dsp_pd_arbiter #(
        .NUM_REQ (NUM_REQ),
        .A_W     (A_W),
        .B_W     (B_W),
        .P_W     (P_W),
        .ID_W    (ID_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .a_i         (a_bus),
        .b_i         (b_bus),
        .pattern_i   (pat_bus),
        .mask_i      (mask_bus),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_prod_o  (rsp_prod),
        .rsp_match_o (rsp_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        a_bus    = '0;
        b_bus    = '0;
        pat_bus  = '0;
        mask_bus = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_bus[i*A_W +: A_W]    = a_arr[i];
            b_bus[i*B_W +: B_W]    = b_arr[i];
            pat_bus[i*P_W +: P_W]  = pat_arr[i];
            mask_bus[i*P_W +: P_W] = mask_arr[i];
        end
    end

    // Requester rule: once raised, valid stays up until accepted.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
        assert property (@(posedge clk) disable iff (!rst_n)
                         (req_valid[g] && !req_ready[g]) |=> req_valid[g])
            else $error("requester %0d dropped valid before acceptance", g);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [P_W-1:0] f_prod(input logic signed [A_W-1:0] a,
                                              input logic signed [B_W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[P_W-1:0];
    endfunction

    function automatic logic f_match(input logic [P_W-1:0] p,
                                     input logic [P_W-1:0] pat,
                                     input logic [P_W-1:0] mask);
        return (((p ^ pat) & ~mask) == '0);
    endfunction

    task automatic new_rand(input int i);
        logic [P_W-1:0] p;
        logic [P_W-1:0] m;
        a_arr[i] = A_W'($urandom);
        b_arr[i] = B_W'($urandom);
        if ($urandom_range(0, 3) == 0) m = '1;
        else m = P_W'($urandom_range(0, 255));
        p = f_prod(a_arr[i], b_arr[i]);
        if ($urandom_range(0, 1) == 1) pat_arr[i] = p ^ (P_W'($urandom) & m);
        else pat_arr[i] = p ^ (P_W'(1) << $urandom_range(0, P_W - 1));
        mask_arr[i] = m;
    endtask

    task automatic set_req(input int i, input logic signed [A_W-1:0] a,
                           input logic signed [B_W-1:0] b,
                           input logic [P_W-1:0] pat, input logic [P_W-1:0] mask);
        a_arr[i]     = a;
        b_arr[i]     = b;
        pat_arr[i]   = pat;
        mask_arr[i]  = mask;
        remaining[i] = 1;
        req_valid[i] = 1'b1;
    endtask

    // Grant prediction, scoreboard pop on handshake, scoreboard push on accept.
    task automatic monitor(output logic [NUM_REQ-1:0] acc);
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t e;
        int   j;
        bit   adv;
        acc = '0;
        if (rst_n !== 1'b1) begin
            m_ptr = 0;
            return;
        end
        adv = (rsp_valid !== 1'b1) || (rsp_ready === 1'b1);
        exp_rdy = '0;
        if (adv) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (m_ptr + k) % NUM_REQ;
                if (exp_rdy == '0 && req_valid[j]) exp_rdy[j] = 1'b1;
            end
        end
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_rsp cyc=%0d id=%0d prod=%h", cyc, rsp_id, rsp_prod);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_prod !== e.prod || rsp_match !== e.match) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got id=%0d prod=%h match=%b exp id=%0d prod=%h match=%b",
                             cyc, rsp_id, rsp_prod, rsp_match, e.id, e.prod, e.match);
                end
                rsp_count++;
                last_rsp_cyc = cyc;
                last_id      = rsp_id;
                last_prod    = rsp_prod;
                last_match   = rsp_match;
                if (mark_first) begin
                    first_rsp_cyc = cyc;
                    mark_first    = 1'b0;
                end
            end
        end
        acc = req_valid & req_ready;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc[k]) begin
                e.id    = ID_W'(k);
                e.prod  = f_prod(a_arr[k], b_arr[k]);
                e.match = f_match(e.prod, pat_arr[k], mask_arr[k]);
                sb.push_back(e);
                m_ptr = (k + 1) % NUM_REQ;
                acc_count++;
                last_acc_cyc = cyc;
            end
        end
    endtask

    // One clock: observe at the falling edge, then update requesters 1 time
    // unit after the rising edge.
    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        monitor(acc);
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                remaining[i]--;
                if (remaining[i] <= 0) req_valid[i] = 1'b0;
                else new_rand(i);
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!(req_valid == '0 && sb.size() == 0 && rsp_valid !== 1'b1)) begin
            if (n >= max_cyc) begin
                checks++;
                errors++;
                $display("FAIL timeout_%s pending=%0d req_valid=%b", name, sb.size(), req_valid);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = '0; b_arr[i] = '0; pat_arr[i] = '0; mask_arr[i] = '0;
            remaining[i] = 0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_prod !== '0) begin errors++; $display("FAIL reset_prod got=%h exp=0", rsp_prod); end
        checks++; if (rsp_match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", rsp_match); end
        req_valid = '1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%b exp=0", rsp_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 27'sd10, 15'sd10, 42'd100, 42'd0);
        wait_idle(30, "single");
        checks++; if (last_prod !== 42'd100) begin errors++; $display("FAIL single_prod got=%0d exp=100", last_prod); end
        checks++; if (last_match !== 1'b1) begin errors++; $display("FAIL single_match got=%b exp=1", last_match); end
        checks++; if (last_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", last_id); end
        checks++;
        if (last_rsp_cyc - last_acc_cyc != 3) begin
            errors++;
            $display("FAIL single_latency got=%0d exp=3", last_rsp_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_mask();
        set_req(2, 27'sd10, 15'sd14, 42'd100, 42'd0);
        wait_idle(30, "mask0");
        checks++; if (last_prod !== 42'd140) begin errors++; $display("FAIL mask0_prod got=%0d exp=140", last_prod); end
        checks++; if (last_match !== 1'b0) begin errors++; $display("FAIL mask0_match got=%b exp=0", last_match); end
        checks++; if (last_id !== 2'd2) begin errors++; $display("FAIL mask0_id got=%0d exp=2", last_id); end
        set_req(2, 27'sd10, 15'sd14, 42'd100, 42'hFF);
        wait_idle(30, "maskff");
        checks++; if (last_prod !== 42'd140) begin errors++; $display("FAIL maskff_prod got=%0d exp=140", last_prod); end
        checks++; if (last_match !== 1'b1) begin errors++; $display("FAIL maskff_match got=%b exp=1", last_match); end
    endtask

    task automatic test_signed();
        set_req(1, -27'sd3, 15'sd5, 42'h3FFFFFFFFF1, 42'd0);
        wait_idle(30, "signed");
        checks++; if (last_prod !== 42'h3FFFFFFFFF1) begin errors++; $display("FAIL signed_prod got=%h exp=3fffffffff1", last_prod); end
        checks++; if (last_match !== 1'b1) begin errors++; $display("FAIL signed_match got=%b exp=1", last_match); end
        checks++; if (last_id !== 2'd1) begin errors++; $display("FAIL signed_id got=%0d exp=1", last_id); end
    endtask

    task automatic test_boundary();
        set_req(3, 27'sh4000000, 15'sh4000, 42'h100_0000_0000, 42'd0);
        wait_idle(30, "mostneg");
        checks++; if (last_prod !== 42'h100_0000_0000) begin errors++; $display("FAIL mostneg_prod got=%h exp=10000000000", last_prod); end
        checks++; if (last_match !== 1'b1) begin errors++; $display("FAIL mostneg_match got=%b exp=1", last_match); end
        set_req(3, 27'sd12345, -15'sd777, 42'h155_5555_5555, '1);
        wait_idle(30, "maskones");
        checks++; if (last_match !== 1'b1) begin errors++; $display("FAIL maskones_match got=%b exp=1", last_match); end
        checks++; if (last_id !== 2'd3) begin errors++; $display("FAIL maskones_id got=%0d exp=3", last_id); end
    endtask

    task automatic test_back_to_back();
        int base_rsp;
        int base_acc;
        base_rsp = rsp_count;
        base_acc = acc_count;
        for (int i = 0; i < NUM_REQ; i++) begin
            new_rand(i);
            remaining[i] = 3;
        end
        mark_first = 1'b1;
        req_valid  = '1;
        wait_idle(60, "b2b");
        checks++; if (acc_count - base_acc != 12) begin errors++; $display("FAIL b2b_accepts got=%0d exp=12", acc_count - base_acc); end
        checks++; if (rsp_count - base_rsp != 12) begin errors++; $display("FAIL b2b_responses got=%0d exp=12", rsp_count - base_rsp); end
        checks++;
        if (last_rsp_cyc - first_rsp_cyc != 11) begin
            errors++;
            $display("FAIL b2b_throughput span got=%0d exp=11", last_rsp_cyc - first_rsp_cyc);
        end
        checks++; if (last_id !== 2'd3) begin errors++; $display("FAIL b2b_last_id got=%0d exp=3", last_id); end
    endtask

    task automatic test_backpressure();
        int base_rsp;
        int base_acc;
        int n;
        logic [P_W-1:0]  held_prod;
        logic [ID_W-1:0] held_id;
        base_rsp = rsp_count;
        base_acc = acc_count;
        for (int i = 0; i < NUM_REQ; i++) begin
            new_rand(i);
            remaining[i] = 2;
        end
        req_valid = '1;
        n = 0;
        while (acc_count - base_acc < 2 && n < 10) begin tick(); n++; end
        rsp_ready = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 6) begin tick(); n++; end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise got=%b exp=1", rsp_valid); end
        held_prod = rsp_prod;
        held_id   = rsp_id;
        repeat (5) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_prod !== held_prod || rsp_id !== held_id || req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold got v=%b id=%0d prod=%h rdy=%b exp v=1 id=%0d prod=%h rdy=0000",
                         rsp_valid, rsp_id, rsp_prod, req_ready, held_id, held_prod);
            end
        end
        checks++; if (rsp_count != base_rsp) begin errors++; $display("FAIL bp_no_consume got=%0d exp=%0d", rsp_count, base_rsp); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_count != base_rsp + 1) begin errors++; $display("FAIL bp_release got=%0d exp=%0d", rsp_count, base_rsp + 1); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_next_follows got=%b exp=1", rsp_valid); end
        wait_idle(60, "bp");
        checks++; if (acc_count - base_acc != 8) begin errors++; $display("FAIL bp_accepts got=%0d exp=8", acc_count - base_acc); end
        checks++; if (rsp_count - base_rsp != 8) begin errors++; $display("FAIL bp_responses got=%0d exp=8", rsp_count - base_rsp); end
    endtask

    task automatic test_reset_midop();
        int n;
        int base_rsp;
        for (int i = 0; i < NUM_REQ; i++) begin
            new_rand(i);
            remaining[i] = 5;
        end
        req_valid = '1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midop_fill got=%b exp=1", rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_async_clear got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL midop_ready_in_reset got=%b exp=0000", req_ready); end
        sb.delete();
        m_ptr = 0;
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        req_valid = '0;
        set_req(1, 27'sd7, 15'sd6, 42'd42, 42'd0);
        set_req(3, -27'sd8, 15'sd9, 42'd0, 42'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midop_first_grant got=%b exp=0010", req_ready); end
        base_rsp = rsp_count;
        wait_idle(30, "midop");
        checks++; if (rsp_count - base_rsp != 2) begin errors++; $display("FAIL midop_responses got=%0d exp=2", rsp_count - base_rsp); end
        checks++; if (last_id !== 2'd3) begin errors++; $display("FAIL midop_last_id got=%0d exp=3", last_id); end
        checks++; if (last_prod !== -42'sd72) begin errors++; $display("FAIL midop_last_prod got=%h exp=-72", last_prod); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask();
        test_signed();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_pd_arbiter.md
Name: dsp_pd_arbiter

Overview:
- Shares one signed multiply + masked pattern-detect pipeline (DSP-slice style) between NUM_REQ requesters.
- A round-robin arbiter accepts at most one operand set per cycle and tags it with the requester ID.
- A 3-stage pipeline returns the product, match flag and ID on a single response channel with backpressure.
- Sits between the control/requester logic and the DSP datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 27, signed operand A width.
- B_W, 15, signed operand B width.
- P_W, 42, product/pattern/mask width; must equal A_W+B_W (full-precision product, no truncation).
- ID_W, 2, requester ID width; clog2(NUM_REQ).

Ports:
- clk_i  in  1  rising-edge clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester grant/ready, one-hot or zero.
- a_i  in  NUM_REQ*A_W  packed signed A operands, requester i in slice i.
- b_i  in  NUM_REQ*B_W  packed signed B operands.
- pattern_i  in  NUM_REQ*P_W  packed compare patterns.
- mask_i  in  NUM_REQ*P_W  packed masks; bit=1 means ignore that bit.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  ID_W  requester ID of the response.
- rsp_prod_o  out  P_W  signed product a*b.
- rsp_match_o  out  1  1 when ((prod ^ pattern) & ~mask) == 0.

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: rsp_valid_o=0, rsp_id_o=0, rsp_prod_o=0, rsp_match_o=0, all stage valids=0, RR pointer=0. req_ready_o=0 while rst_ni is low.
- Advance enable: adv = !rsp_valid_o || rsp_ready_i. All stages shift together only when adv=1. When adv=0, every stage register holds, and all response outputs stay stable.
- Arbitration:
  - Combinational from req_valid_i, RR pointer and adv.
  - Search starts at the pointer and wraps modulo NUM_REQ. The first requester found with valid=1 gets req_ready_o[i]=1, but only if adv=1.
  - A request is accepted when req_valid_i[i] & req_ready_o[i].
  - On acceptance, pointer <= i+1 mod NUM_REQ. With no acceptance, the pointer holds.
- Requester rule: a requester holds valid and its data stable until accepted. Valid may not drop before acceptance; the bench checks this as an assertion.
- Stage 1 (accept): register A, B, pattern, mask, ID, v1.
  - Stage 1 loads valid=0 (bubble) when no request is accepted and adv=1.
- Stage 2: signed full product, prod = $signed(A)*$signed(B), sign-extended to P_W. Carries pattern, mask, ID, v2.
- Stage 3 (output): rsp_prod_o, rsp_match_o, rsp_id_o, rsp_valid_o.
  - Match is computed from the stage-2 product, pattern and mask.
- Latency: acceptance at edge N, with adv continuously 1, gives rsp_valid_o=1 after edge N+3 (3 cycles). Throughput is 1 per cycle.
- Bubbles: bubbles are not collapsed while stalled. The pipeline is a rigid shift register.
- Boundary conditions:
  - Multiple simultaneous requests: exactly one grant.
  - Pointer wrap from NUM_REQ-1 to 0.
  - rsp_valid_o=1, rsp_ready_i=0 while requests pend: no grant; response held.
  - Output-register data for invalid slots: don't-care; the bench checks data only when valid.
  - Mask all ones: match=1 regardless of product.
  - Most-negative operands (-2^26 * -2^14 = 2^40): representable, no overflow.
- Reset mid-operation: all in-flight data is dropped immediately (asynchronous) and the pointer returns to 0. After reset release, the first grant goes to the lowest-index valid requester at or after 0.

Decomposition:
- Shared package dsp_pd_pkg: default widths (A_W, B_W, P_W) and function pd_match(prod, pattern, mask).
- One sub-module, dsp_pd_pipe: the 3-stage multiply/compare pipeline with tag pass-through and adv enable.
- The arbiter and operand mux stay in the top level.

Test Plan:
- Single request, requester 0: a=10, b=10, pattern=100, mask=0 -> 3 cycles later rsp_valid=1, prod=100, match=1, id=0.
- Requester 2: a=10, b=14, pattern=100, mask=0 -> prod=140, match=0. Repeat with mask=0xFF -> match=1. Upper bits are equal, so the masked compare passes.
- Signed operands, requester 1: a=-3, b=5, pattern=42'h3FFFFFFFFF1, mask=0 -> prod=-15, match=1, id=1.
- All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1,… and responses arrive in that ID order, one per cycle.
- Backpressure: after 2 accepts, drive rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with stable prod/id and req_ready=0. Then drive rsp_ready=1 -> the held response completes and the next follows the next cycle, with none lost or duplicated.
- Reset mid-op: assert rst_ni=0 with 3 transactions in flight -> rsp_valid_o=0 immediately, without waiting for a clock edge. After release with req_valid=4'b1010 -> first grant goes to requester 1.
